// File: rtl/lcd_text_frame_driver.sv
// ---------------------------------------------------------------------------
// lcd_text_frame_driver
//   HD44780 8-bit text-LCD driver for a 2 x COLS character panel. After reset
//   it issues the power-up command sequence (0x38, 0x0C, 0x01, 0x06), then
//   streams a 2 x COLS character buffer to the panel: a DDRAM address command
//   per row followed by COLS data writes. Frames run back-to-back
//   (AUTO_REFRESH=1) or only on refresh_req / pending buffer writes.
//
// Ports
//   clk_1MHz     system clock
//   rst          synchronous active-high reset
//   wr_en        write wr_char into buffer[wr_row][wr_col]
//   wr_row       0 = line 1, 1 = line 2
//   wr_col       column; values >= COLS are dropped
//   wr_char      character code
//   refresh_req  one-cycle frame request (only honoured when idle/at frame end)
//   busy         high during init or a frame
//   frame_done   one-cycle pulse at the end of each frame
//   lcd_rs       0 = command, 1 = data
//   lcd_rw       always 0 (write only)
//   lcd_en       enable strobe
//   lcd_data     data bus
// ---------------------------------------------------------------------------
// state   | meaning
// S_RESET | just out of reset, launches the first init command next edge
// S_INIT  | sending init command idx_q (0..3)
// S_ADDR1 | sending DDRAM address 0x80 (line 1)
// S_CHR1  | sending line-1 character idx_q
// S_ADDR2 | sending DDRAM address 0xC0 (line 2)
// S_CHR2  | sending line-2 character idx_q
// S_IDLE  | waiting for refresh_req or a pending write (AUTO_REFRESH=0)
// ---------------------------------------------------------------------------
module lcd_text_frame_driver #(
  parameter int COLS         = 16,
  parameter int EN_CYCLES    = 500,
  parameter int GAP_CYCLES   = 500,
  parameter int CLEAR_CYCLES = 2000,
  parameter bit AUTO_REFRESH = 1'b1,
  localparam int CW          = $clog2(COLS)
) (
  input  logic          clk_1MHz,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  input  logic          refresh_req,
  output logic          busy,
  output logic          frame_done,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_data
);

  localparam int TMAX_EG = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int TMAX    = (TMAX_EG > CLEAR_CYCLES) ? TMAX_EG : CLEAR_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_INIT = CW'(3);

  typedef enum logic [2:0] {
    S_RESET, S_INIT, S_ADDR1, S_CHR1, S_ADDR2, S_CHR2, S_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          en_phase_q, en_phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          dirty_q, dirty_d;
  logic [7:0]    char_q [2][COLS];
  logic [7:0]    char_d [2][COLS];

  state_t        succ_state;
  logic [CW-1:0] succ_idx;
  logic          frame_end;
  logic          launch_rs;
  logic [7:0]    launch_data;
  logic          in_xfer;
  logic          advance;
  logic          wr_ok;

  assign wr_ok   = wr_en && (int'(wr_col) < COLS);
  assign in_xfer = (state_q != S_RESET) && (state_q != S_IDLE);
  // A new item starts when the current gap expires, straight out of reset,
  // or from idle when something asks for a frame.
  assign advance = (state_q == S_RESET) ||
                   ((state_q == S_IDLE) && (dirty_q || refresh_req)) ||
                   (in_xfer && !en_phase_q && (timer_q == '0));

  // Item that follows the one currently on the bus.
  always_comb begin
    succ_state = S_RESET;
    succ_idx   = '0;
    frame_end  = 1'b0;
    case (state_q)
      S_RESET: succ_state = S_INIT;
      S_INIT: begin
        if (idx_q == LAST_INIT) succ_state = S_ADDR1;
        else begin
          succ_state = S_INIT;
          succ_idx   = idx_q + 1'b1;
        end
      end
      S_ADDR1: succ_state = S_CHR1;
      S_CHR1: begin
        if (idx_q == LAST_COL) succ_state = S_ADDR2;
        else begin
          succ_state = S_CHR1;
          succ_idx   = idx_q + 1'b1;
        end
      end
      S_ADDR2: succ_state = S_CHR2;
      S_CHR2: begin
        if (idx_q == LAST_COL) begin
          frame_end  = 1'b1;
          succ_state = (AUTO_REFRESH || dirty_q || refresh_req) ? S_ADDR1 : S_IDLE;
        end else begin
          succ_state = S_CHR2;
          succ_idx   = idx_q + 1'b1;
        end
      end
      S_IDLE:  succ_state = S_ADDR1;
      default: succ_state = S_RESET;
    endcase
  end

  // Bus value for the item being launched; characters are sampled here.
  always_comb begin
    launch_rs   = 1'b0;
    launch_data = 8'h00;
    case (succ_state)
      S_INIT: begin
        case (succ_idx[1:0])
          2'd0:    launch_data = 8'h38;
          2'd1:    launch_data = 8'h0C;
          2'd2:    launch_data = 8'h01;
          default: launch_data = 8'h06;
        endcase
      end
      S_ADDR1: launch_data = 8'h80;
      S_CHR1: begin
        launch_rs   = 1'b1;
        launch_data = char_q[0][succ_idx];
      end
      S_ADDR2: launch_data = 8'hC0;
      S_CHR2: begin
        launch_rs   = 1'b1;
        launch_data = char_q[1][succ_idx];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    en_phase_d   = en_phase_q;
    timer_d      = timer_q;
    rs_d         = rs_q;
    en_d         = en_q;
    data_d       = data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    dirty_d      = dirty_q;
    char_d       = char_q;

    if (advance) begin
      state_d      = succ_state;
      idx_d        = succ_idx;
      frame_done_d = frame_end;
      if (succ_state == S_IDLE) begin
        busy_d     = 1'b0;
        en_d       = 1'b0;
        en_phase_d = 1'b0;
        timer_d    = '0;
      end else begin
        busy_d     = 1'b1;
        en_d       = 1'b1;
        en_phase_d = 1'b1;
        timer_d    = TW'(EN_CYCLES - 1);
        rs_d       = launch_rs;
        data_d     = launch_data;
        if (succ_state == S_ADDR1) dirty_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        // End of the EN phase; the clear command needs the long settle gap.
        en_d       = 1'b0;
        en_phase_d = 1'b0;
        timer_d    = ((state_q == S_INIT) && (data_q == 8'h01)) ?
                     TW'(CLEAR_CYCLES - 1) : TW'(GAP_CYCLES - 1);
      end
    end

    // A write on the frame-start cycle must survive the dirty clear above.
    if (wr_ok) begin
      char_d[wr_row][wr_col] = wr_char;
      dirty_d                = 1'b1;
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_q      <= S_RESET;
      idx_q        <= '0;
      en_phase_q   <= 1'b0;
      timer_q      <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      dirty_q      <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < COLS; c++) begin
          char_q[r][c] <= 8'h20;
        end
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      en_phase_q   <= en_phase_d;
      timer_q      <= timer_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dirty_q      <= dirty_d;
      char_q       <= char_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_data   = data_q;

endmodule
